// File: rtl/alu_pkg.sv
// Shared widths, opcode and op-class encodings, FSM states and the one-bit shift step
// used by the Stage2 execute unit.
package alu_pkg;

    localparam int N = 32;
    localparam int S = 5;
    localparam int O = 3;

    localparam logic [O-1:0] SHIFT_REG   = 3'b000;
    localparam logic [O-1:0] ARITH_LOGIC = 3'b001;
    localparam logic [O-1:0] MEM_WRITE   = 3'b100;
    localparam logic [O-1:0] MEM_READ    = 3'b101;

    typedef enum logic [O-1:0] {
        OP_ADD  = 3'b000,
        OP_HADD = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LHG  = 3'b111
    } arith_op_e;

    typedef enum logic [O-1:0] {
        SH_SLL = 3'b001,
        SH_SLA = 3'b011,
        SH_SRL = 3'b101,
        SH_SRA = 3'b111
    } shift_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    // Unknown shift codes leave the value untouched, so the result is aluin1 unshifted.
    function automatic logic [N-1:0] shift_step(input logic [O-1:0] op, input logic [N-1:0] w);
        logic [N-1:0] r;
        r = w;
        case (op)
            SH_SLL, SH_SLA: r = {w[N-2:0], 1'b0};
            SH_SRL:         r = {1'b0, w[N-1:1]};
            SH_SRA:         r = {w[N-1], w[N-1:1]};
            default:        r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: loads value/amount on start, shifts one bit per cycle after that.
// done is high in the cycle whose closing edge applies the final step; result is that step's output.
module alu_serial_shifter
    import alu_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] value,
    input  logic [S-1:0] amount,
    input  logic [O-1:0] op,
    output logic [N-1:0] result,
    output logic         done
);

    logic [N-1:0] work;
    logic [S-1:0] cnt;
    logic [O-1:0] op_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work <= '0;
            cnt  <= '0;
            op_q <= '0;
        end else if (start) begin
            work <= value;
            cnt  <= amount;
            op_q <= op;
        end else if (cnt != '0) begin
            work <= shift_step(op_q, work);
            cnt  <= cnt - S'(1);
        end
    end

    assign result = shift_step(op_q, work);
    assign done   = (cnt == S'(1));

endmodule

// File: rtl/stage2_alu_execute.sv
// Stage2 execute: single-cycle arith/logic, serial shifts (k cycles busy), registered result + 1-cycle valid.
// Requests arriving while busy are dropped; upstream holds enable_ex low while busy.
module stage2_alu_execute
    import alu_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] aluin1,
    input  logic [N-1:0] aluin2,
    input  logic [O-1:0] operation_in,
    input  logic [O-1:0] opselect_in,
    input  logic [S-1:0] shift_number,
    input  logic         enable_arith,
    input  logic         enable_shift,
    output logic [N-1:0] aluout,
    output logic         carry,
    output logic         overflow,
    output logic         aluout_valid,
    output logic         busy
);

    alu_state_e   state, state_nxt;
    logic         accept_arith, accept_shift, shift_start, shift_done;
    logic [N-1:0] shift_res, op_b, arith_res;
    logic         arith_c, arith_v;
    logic [N:0]   sum, diff;
    logic [16:0]  hsum;

    assign accept_arith = (state == ST_IDLE) && enable_arith;
    assign accept_shift = (state == ST_IDLE) && !enable_arith && enable_shift;
    assign shift_start  = accept_shift && (shift_number != '0);
    assign busy         = (state == ST_SHIFT);

    // Memory-read data is already steered onto operand 2 by Stage1; both classes share one decode.
    always_comb begin
        op_b = aluin2;
        case (opselect_in)
            MEM_READ: op_b = aluin2;
            default:  op_b = aluin2;
        endcase
    end

    assign sum  = {1'b0, aluin1} + {1'b0, op_b};
    assign diff = {1'b0, aluin1} - {1'b0, op_b};
    assign hsum = {1'b0, aluin1[15:0]} + {1'b0, op_b[15:0]};

    always_comb begin
        arith_res = '0;
        arith_c   = 1'b0;
        arith_v   = 1'b0;
        case (operation_in)
            OP_ADD: begin
                arith_res = sum[N-1:0];
                arith_c   = sum[N];
                arith_v   = (aluin1[N-1] == op_b[N-1]) && (sum[N-1] != aluin1[N-1]);
            end
            OP_HADD: begin
                arith_res = {{(N-16){hsum[15]}}, hsum[15:0]};
                arith_c   = hsum[16];
                arith_v   = (aluin1[15] == op_b[15]) && (hsum[15] != aluin1[15]);
            end
            OP_SUB: begin
                arith_res = diff[N-1:0];
                arith_c   = diff[N];
                arith_v   = (aluin1[N-1] != op_b[N-1]) && (diff[N-1] != aluin1[N-1]);
            end
            OP_NOT:  arith_res = ~op_b;
            OP_AND:  arith_res = aluin1 & op_b;
            OP_OR:   arith_res = aluin1 | op_b;
            OP_XOR:  arith_res = aluin1 ^ op_b;
            OP_LHG:  arith_res = {op_b[15:0], {(N-16){1'b0}}};
            default: arith_res = '0;
        endcase
    end

    alu_serial_shifter u_shifter (
        .clock  (clock),
        .reset  (reset),
        .start  (shift_start),
        .value  (aluin1),
        .amount (shift_number),
        .op     (operation_in),
        .result (shift_res),
        .done   (shift_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (shift_start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (shift_done)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Shifts update aluout only; carry/overflow keep the last arithmetic result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout       <= '0;
            carry        <= 1'b0;
            overflow     <= 1'b0;
            aluout_valid <= 1'b0;
        end else begin
            aluout_valid <= 1'b0;
            if (accept_arith) begin
                aluout       <= arith_res;
                carry        <= arith_c;
                overflow     <= arith_v;
                aluout_valid <= 1'b1;
            end else if (accept_shift && (shift_number == '0)) begin
                aluout       <= aluin1;
                aluout_valid <= 1'b1;
            end else if (busy && shift_done) begin
                aluout       <= shift_res;
                aluout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage2_alu_execute.sv
// Randomized and directed bench for stage2_alu_execute against an integer-arithmetic reference model.
module tb_stage2_alu_execute;
    import alu_pkg::*;

    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] aluin1, aluin2, aluout;
    logic [2:0]  operation_in, opselect_in;
    logic [4:0]  shift_number;
    logic        enable_arith, enable_shift;
    logic        carry, overflow, aluout_valid, busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mc, mv;

    logic [31:0] ra, rb, rer;
    logic [2:0]  rop;
    logic        rec, rev;
    int          rk;

    always #5 clock = ~clock;

    stage2_alu_execute dut (
        .clock        (clock),
        .reset        (reset),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .operation_in (operation_in),
        .opselect_in  (opselect_in),
        .shift_number (shift_number),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .aluout       (aluout),
        .carry        (carry),
        .overflow     (overflow),
        .aluout_valid (aluout_valid),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output logic [31:0] r, output logic c, output logic v);
        longint ua, ub, sa, sb, t;
        int     hu, hs;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                t = ua + ub; r = t[31:0]; c = t[32];
                t = sa + sb; v = (t > MAX32) || (t < MIN32);
            end
            3'd1: begin
                hu = int'(a[15:0]) + int'(b[15:0]);
                hs = int'($signed(a[15:0])) + int'($signed(b[15:0]));
                r = {{16{hu[15]}}, hu[15:0]};
                c = hu[16];
                v = (hs > 32767) || (hs < -32768);
            end
            3'd2: begin
                t = ua - ub; r = t[31:0]; c = (a < b);
                t = sa - sb; v = (t > MAX32) || (t < MIN32);
            end
            3'd3: r = ~b;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = {b[15:0], 16'h0000};
        endcase
    endfunction

    function automatic logic [31:0] model_shift(input logic [2:0] op, input logic [31:0] a, input int k);
        case (op)
            3'b001, 3'b011: return a << k;
            3'b101:         return a >> k;
            3'b111:         return $unsigned($signed(a) >>> k);
            default:        return a;
        endcase
    endfunction

    task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit both, input logic [31:0] er, input logic ec, input logic ev);
        aluin1 = a; aluin2 = b; operation_in = op;
        opselect_in  = ($urandom_range(0, 1) != 0) ? MEM_READ : ARITH_LOGIC;
        shift_number = 5'($urandom_range(0, 31));
        enable_arith = 1'b1; enable_shift = both;
        @(posedge clock); #1;
        enable_arith = 1'b0; enable_shift = 1'b0;
        check({tag, "_res"},   aluout, er);
        check({tag, "_carry"}, carry, ec);
        check({tag, "_ovf"},   overflow, ev);
        check({tag, "_vld"},   aluout_valid, 1);
        check({tag, "_busy"},  busy, 0);
        mc = ec; mv = ev;
        @(posedge clock); #1;
        check({tag, "_vld_off"}, aluout_valid, 0);
    endtask

    task automatic run_shift(input string tag, input logic [2:0] op, input logic [31:0] a, input int k,
                             input bit probe, input logic [31:0] er);
        int cyc;
        aluin1 = a; aluin2 = $urandom; operation_in = op; opselect_in = SHIFT_REG;
        shift_number = 5'(k);
        enable_shift = 1'b1; enable_arith = 1'b0;
        @(posedge clock); #1;
        enable_shift = 1'b0;
        if (k == 0) begin
            check({tag, "_busy0"}, busy, 0);
        end else begin
            check({tag, "_vld_early"}, aluout_valid, 0);
            if (probe) begin
                aluin1 = 32'h0000_0001; aluin2 = 32'h0000_0001; operation_in = 3'd0;
                enable_arith = 1'b1;
            end
            cyc = 0;
            while (busy && cyc < 40) begin
                cyc++;
                @(posedge clock); #1;
            end
            enable_arith = 1'b0;
            check({tag, "_busy_cycles"}, cyc, k);
        end
        check({tag, "_res"},   aluout, er);
        check({tag, "_vld"},   aluout_valid, 1);
        check({tag, "_carry"}, carry, mc);
        check({tag, "_ovf"},   overflow, mv);
        @(posedge clock); #1;
        check({tag, "_vld_off"}, aluout_valid, 0);
        check({tag, "_res_hold"}, aluout, er);
    endtask

    initial begin
        reset = 1'b1;
        aluin1 = '0; aluin2 = '0; operation_in = '0; opselect_in = ARITH_LOGIC;
        shift_number = '0; enable_arith = 1'b0; enable_shift = 1'b0;
        mc = 1'b0; mv = 1'b0;
        #1;
        check("rst_aluout", aluout, 0);
        check("rst_vld", aluout_valid, 0);
        check("rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Produce a nonzero result with carry set, then reset asynchronously mid-cycle.
        aluin1 = 32'hC000_0000; aluin2 = 32'hC000_0000; operation_in = 3'd0; enable_arith = 1'b1;
        @(posedge clock); #1;
        enable_arith = 1'b0;
        check("pre_rst_res", aluout, 32'h8000_0000);
        #2 reset = 1'b1;
        #1;
        check("arst_aluout", aluout, 0);
        check("arst_carry", carry, 0);
        check("arst_ovf", overflow, 0);
        check("arst_vld", aluout_valid, 0);
        check("arst_busy", busy, 0);
        #3 reset = 1'b0;
        @(posedge clock); #1;
        mc = 1'b0; mv = 1'b0;

        run_arith("add_wrap",   3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0);
        run_arith("sub_ovf",    3'd2, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 1);
        run_arith("sub_borrow", 3'd2, 32'h0000_0001, 32'h0000_0002, 0, 32'hFFFF_FFFF, 1, 0);
        run_arith("hadd_ovf",   3'd1, 32'h0000_7FFF, 32'h0000_0001, 0, 32'hFFFF_8000, 0, 1);
        run_arith("lhg",        3'd7, 32'h5555_5555, 32'h1234_ABCD, 0, 32'hABCD_0000, 0, 0);
        run_arith("add_c",      3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'h0000_0001, 1, 0);
        run_shift("sra4",  3'b111, 32'h8000_0010, 4,  1, 32'hF800_0001);
        run_shift("sll0",  3'b001, 32'hDEAD_BEEF, 0,  0, 32'hDEAD_BEEF);
        run_shift("sll31", 3'b001, 32'h0000_0001, 31, 0, 32'h8000_0000);

        // Reset ten cycles into a long shift: nothing may complete afterwards.
        aluin1 = 32'h0000_0001; operation_in = 3'b001; shift_number = 5'd31; enable_shift = 1'b1;
        @(posedge clock); #1;
        enable_shift = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("mid_shift_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("shift_rst_busy", busy, 0);
        check("shift_rst_aluout", aluout, 0);
        check("shift_rst_vld", aluout_valid, 0);
        #3 reset = 1'b0;
        mc = 1'b0; mv = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_aluout", aluout, 0);

        run_arith("both_en", 3'd0, 32'd2, 32'd3, 1, 32'd5, 0, 0);

        for (int i = 0; i < 60; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 1) ra = ra & 32'h8000_FFFF;
            if ($urandom_range(0, 3) != 0) begin
                model_arith(rop, ra, rb, rer, rec, rev);
                run_arith("rnd_arith", rop, ra, rb, bit'($urandom_range(0, 1)), rer, rec, rev);
            end else begin
                rk  = $urandom_range(0, 31);
                rer = model_shift(rop, ra, rk);
                run_shift("rnd_shift", rop, ra, rk, bit'($urandom_range(0, 1)), rer);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
